// File: rtl/player_multishot_pkg.sv
// Shared helpers for the player controller: field-width derivation and the
// fixed playfield positions (ship start column, bullet spawn row).
package player_multishot_pkg;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int width_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Column the ship returns to after reset or a round clear.
  function automatic int start_col(input int cols);
    return cols / 2;
  endfunction

  // Row a freshly fired bullet appears on (one above the ship row).
  function automatic int spawn_row(input int rows);
    return rows - 2;
  endfunction

endpackage

// File: rtl/player_multishot_edge_pulse_sync.sv
// Brings an asynchronous button level into clk, then emits a registered
// one-cycle pulse on each rising edge of the synchronised level.
module edge_pulse_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  // Two-flop synchroniser, history flop and registered rising-edge pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2;
      pulse <= sync2 & ~prev;
    end
  end

endmodule

// File: rtl/player_multishot.sv
// Player controller: ship column, a pool of independent bullets, shot
// cooldown, saturating hit score and a start pulse. Movement and bullets
// only advance on the game-rate strobe 'tick'; hits act in any cycle.
module player_multishot
  import player_multishot_pkg::*;
#(
  parameter int COLS        = 20,
  parameter int ROWS        = 10,
  parameter int NUM_BULLETS = 2,
  parameter int COOLDOWN    = 3,
  parameter int SCORE_W     = 8,
  localparam int POS_W      = width_for(COLS),
  localparam int Y_W        = width_for(ROWS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         tick,
  input  logic                         left,
  input  logic                         right,
  input  logic                         shoot,
  input  logic                         start,
  input  logic                         score_clear,
  input  logic [NUM_BULLETS-1:0]       hit,
  output logic [POS_W-1:0]             pos_ship,
  output logic                         start_pulse,
  output logic [NUM_BULLETS*POS_W-1:0] bullet_x,
  output logic [NUM_BULLETS*Y_W-1:0]   bullet_y,
  output logic [NUM_BULLETS-1:0]       bullet_active,
  output logic [SCORE_W-1:0]           score
);

  localparam int CD_W      = width_for(COOLDOWN + 1);
  localparam int CNT_W     = width_for(NUM_BULLETS + 1);
  localparam int START_COL = start_col(COLS);
  localparam int SPAWN_ROW = spawn_row(ROWS);

  logic                   left_edge, right_edge, shoot_edge;
  logic                   pend_left, pend_right, pend_shot;
  logic [CD_W-1:0]        cooldown;
  logic                   fire_ok, found;
  logic [NUM_BULLETS-1:0] fire_sel;
  logic [CNT_W-1:0]       hit_cnt;
  logic [SCORE_W:0]       score_sum;

  edge_pulse_sync u_left  (.clk(clk), .reset(reset), .din(left),  .pulse(left_edge));
  edge_pulse_sync u_right (.clk(clk), .reset(reset), .din(right), .pulse(right_edge));
  edge_pulse_sync u_shoot (.clk(clk), .reset(reset), .din(shoot), .pulse(shoot_edge));
  edge_pulse_sync u_start (.clk(clk), .reset(reset), .din(start), .pulse(start_pulse));

  // Pending requests: consumed at a tick, but an edge landing on the tick
  // cycle survives to the following tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_left  <= 1'b0;
      pend_right <= 1'b0;
      pend_shot  <= 1'b0;
    end else if (clear) begin
      pend_left  <= 1'b0;
      pend_right <= 1'b0;
      pend_shot  <= 1'b0;
    end else begin
      pend_left  <= (pend_left  & ~tick) | left_edge;
      pend_right <= (pend_right & ~tick) | right_edge;
      pend_shot  <= (pend_shot  & ~tick) | shoot_edge;
    end
  end

  // Ship column: single-step move at a tick, clamped at both walls;
  // opposing requests cancel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_ship <= POS_W'(START_COL);
    end else if (clear) begin
      pos_ship <= POS_W'(START_COL);
    end else if (tick) begin
      if (pend_left && !pend_right && pos_ship != '0)
        pos_ship <= pos_ship - POS_W'(1);
      else if (pend_right && !pend_left && pos_ship != POS_W'(COLS - 1))
        pos_ship <= pos_ship + POS_W'(1);
    end
  end

  // Lowest-index free slot takes the shot; freedom is judged on the
  // registered flags so a slot hit during this tick is not reused yet.
  always_comb begin
    fire_ok  = tick & pend_shot & (cooldown == '0);
    fire_sel = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!found && !bullet_active[i]) begin
        fire_sel[i] = fire_ok;
        found       = 1'b1;
      end
    end
  end

  // Cooldown down-counter, reloaded whenever a shot actually fires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cooldown <= '0;
    end else if (clear) begin
      cooldown <= '0;
    end else if (tick) begin
      if (|fire_sel)
        cooldown <= CD_W'(COOLDOWN);
      else if (cooldown != '0)
        cooldown <= cooldown - CD_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
    logic [POS_W-1:0] x_q;
    logic [Y_W-1:0]   y_q;
    logic             act_q;

    // Slot state: a hit retires the bullet before any tick action; an idle
    // slot keeps its last coordinates.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        x_q   <= '0;
        y_q   <= '0;
        act_q <= 1'b0;
      end else if (clear) begin
        act_q <= 1'b0;
      end else if (hit[g] && act_q) begin
        act_q <= 1'b0;
      end else if (fire_sel[g]) begin
        x_q   <= pos_ship;
        y_q   <= Y_W'(SPAWN_ROW);
        act_q <= 1'b1;
      end else if (tick && act_q) begin
        if (y_q == '0)
          act_q <= 1'b0;
        else
          y_q <= y_q - Y_W'(1);
      end
    end

    assign bullet_x[g*POS_W +: POS_W] = x_q;
    assign bullet_y[g*Y_W +: Y_W]     = y_q;
    assign bullet_active[g]           = act_q;
  end

  // Count of valid hits this cycle and the unsaturated new score.
  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < NUM_BULLETS; i++)
      hit_cnt = hit_cnt + CNT_W'(hit[i] & bullet_active[i]);
    score_sum = {1'b0, score} + (SCORE_W + 1)'(hit_cnt);
  end

  // Score: clear wins over same-cycle hits, otherwise saturating add.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      score <= '0;
    else if (score_clear)
      score <= '0;
    else if (score_sum > {1'b0, {SCORE_W{1'b1}}})
      score <= '1;
    else
      score <= score_sum[SCORE_W-1:0];
  end

endmodule

// File: tb/tb_player_multishot.sv
// Bench for player_multishot at default parameters: directed game scenarios
// followed by random play, every cycle compared with a behavioural model.
module tb_player_multishot;

  logic       clk = 1'b0;
  logic       reset, clear, tick, left, right, shoot, start, score_clear;
  logic [1:0] hit;
  logic [4:0] pos_ship;
  logic       start_pulse;
  logic [9:0] bullet_x;
  logic [7:0] bullet_y;
  logic [1:0] bullet_active;
  logic [7:0] score;

  int vectors = 0;
  int miscompares = 0;

  // behavioural model state
  int         m_pos, m_cd, m_score, m_start;
  int         m_x[2], m_y[2], m_act[2];
  bit         m_pl, m_pr, m_ps;
  logic [3:0] prev_btn;
  logic [3:0] hist[3];

  player_multishot dut (
    .clk(clk), .reset(reset), .clear(clear), .tick(tick),
    .left(left), .right(right), .shoot(shoot), .start(start),
    .score_clear(score_clear), .hit(hit),
    .pos_ship(pos_ship), .start_pulse(start_pulse),
    .bullet_x(bullet_x), .bullet_y(bullet_y),
    .bullet_active(bullet_active), .score(score)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_btn(input logic [3:0] m);
    {start, shoot, right, left} = m;
  endtask

  task automatic model_reset();
    m_pos = 10; m_cd = 0; m_score = 0; m_start = 0;
    for (int i = 0; i < 2; i++) begin m_x[i] = 0; m_y[i] = 0; m_act[i] = 0; end
    m_pl = 0; m_pr = 0; m_ps = 0;
    prev_btn = '0;
    for (int i = 0; i < 3; i++) hist[i] = '0;
  endtask

  // One clock of game rules; a button press becomes a usable request
  // three clocks after the level is first sampled high.
  task automatic model_step();
    logic [3:0] rnow, btn;
    int fs, cnt, sum;
    btn  = {start, shoot, right, left};
    rnow = btn & ~prev_btn;
    prev_btn = btn;
    cnt = 0;
    for (int i = 0; i < 2; i++) if (hit[i] && m_act[i] != 0) cnt++;
    sum = m_score + cnt;
    m_score = score_clear ? 0 : ((sum > 255) ? 255 : sum);
    m_start = hist[1][3];
    if (clear) begin
      m_pos = 10; m_cd = 0;
      m_act[0] = 0; m_act[1] = 0;
      m_pl = 0; m_pr = 0; m_ps = 0;
    end else begin
      fs = -1;
      if (tick && m_ps && m_cd == 0)
        for (int i = 0; i < 2; i++) if (fs < 0 && m_act[i] == 0) fs = i;
      for (int i = 0; i < 2; i++) begin
        if (hit[i] && m_act[i] != 0) m_act[i] = 0;
        else if (i == fs) begin m_x[i] = m_pos; m_y[i] = 8; m_act[i] = 1; end
        else if (tick && m_act[i] != 0) begin
          if (m_y[i] == 0) m_act[i] = 0; else m_y[i]--;
        end
      end
      if (tick) begin
        m_cd = (fs >= 0) ? 3 : ((m_cd > 0) ? m_cd - 1 : 0);
        if (m_pl && !m_pr && m_pos > 0) m_pos--;
        else if (m_pr && !m_pl && m_pos < 19) m_pos++;
      end
      m_pl = (m_pl && !tick) || hist[2][0];
      m_pr = (m_pr && !tick) || hist[2][1];
      m_ps = (m_ps && !tick) || hist[2][2];
    end
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = rnow;
  endtask

  task automatic check_all();
    chk("pos_ship", pos_ship, m_pos);
    chk("start_pulse", start_pulse, m_start);
    chk("bullet_x", bullet_x, m_x[1] * 32 + m_x[0]);
    chk("bullet_y", bullet_y, m_y[1] * 16 + m_y[0]);
    chk("bullet_active", bullet_active, m_act[1] * 2 + m_act[0]);
    chk("score", score, m_score);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!reset) model_reset(); else model_step();
    #1;
    check_all();
  endtask

  task automatic tick1();
    tick = 1'b1; cyc(); tick = 1'b0;
  endtask

  task automatic press_tick(input logic [3:0] m);
    set_btn(m); cyc(); set_btn(4'b0000);
    repeat (4) cyc();
    tick1();
  endtask

  task automatic round_hit();
    press_tick(4'b0100);
    hit = 2'b01; cyc(); hit = 2'b00;
    repeat (3) tick1();
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; tick = 1'b0; score_clear = 1'b0; hit = 2'b00;
    set_btn(4'b0000);
    model_reset();
    repeat (2) cyc();
    reset = 1'b1;
    cyc();
    chk("rst_pos", pos_ship, 10);
    chk("rst_score", score, 0);

    // start pulse: high only after the third edge following the press
    set_btn(4'b1000); cyc(); set_btn(4'b0000);
    cyc(); cyc();
    chk("start_hi", start_pulse, 1);
    cyc();
    chk("start_lo", start_pulse, 0);

    // ship clamps at both walls; opposing presses cancel
    repeat (10) press_tick(4'b0001);
    press_tick(4'b0001);
    chk("pos_min", pos_ship, 0);
    repeat (20) press_tick(4'b0010);
    chk("pos_max", pos_ship, 19);
    press_tick(4'b0011);
    chk("pos_both", pos_ship, 19);

    // cooldown, slot exhaustion and bullet flight from column 7
    clear = 1'b1; cyc(); clear = 1'b0;
    chk("clear_pos", pos_ship, 10);
    repeat (3) press_tick(4'b0001);
    chk("pos_7", pos_ship, 7);
    for (int k = 0; k < 9; k++) begin
      press_tick(4'b0100);
      chk("flight_y0", bullet_y[3:0], 8 - k);
      if (k == 0) chk("fire_t0", bullet_active, 2'b01);
      if (k == 4) chk("fire_t4", bullet_active, 2'b11);
      if (k == 8) chk("drop_t8", bullet_active, 2'b11);
    end
    tick1();
    chk("retire_y0", bullet_active, 2'b10);
    chk("hold_x0", bullet_x[4:0], 7);

    // score saturation
    clear = 1'b1; cyc(); clear = 1'b0;
    repeat (254) round_hit();
    chk("score_254", score, 254);
    press_tick(4'b0100);
    repeat (3) tick1();
    press_tick(4'b0100);
    chk("both_active", bullet_active, 2'b11);
    hit = 2'b11; cyc(); hit = 2'b00;
    chk("score_sat", score, 255);
    chk("hit_retire", bullet_active, 2'b00);
    repeat (3) tick1();
    press_tick(4'b0100);
    hit = 2'b01; cyc(); hit = 2'b00;
    chk("score_hold", score, 255);
    hit = 2'b11; cyc(); hit = 2'b00;
    chk("hit_idle", score, 255);
    chk("hit_idle_act", bullet_active, 2'b00);

    // score_clear beats a same-cycle hit; clear keeps the score
    repeat (3) tick1();
    press_tick(4'b0100);
    hit = 2'b01; score_clear = 1'b1; cyc(); hit = 2'b00; score_clear = 1'b0;
    chk("sclr_hit", score, 0);
    repeat (3) tick1();
    press_tick(4'b0100);
    hit = 2'b01; cyc(); hit = 2'b00;
    chk("score_1", score, 1);
    repeat (3) tick1();
    press_tick(4'b0001);
    press_tick(4'b0100);
    chk("pre_clear_pos", pos_ship, 9);
    clear = 1'b1; cyc(); clear = 1'b0;
    chk("clr_pos", pos_ship, 10);
    chk("clr_act", bullet_active, 2'b00);
    chk("clr_score", score, 1);

    // asynchronous reset mid-game
    repeat (4) round_hit();
    press_tick(4'b0100);
    repeat (3) tick1();
    press_tick(4'b0100);
    chk("mid_act", bullet_active, 2'b11);
    chk("mid_score", score, 5);
    #2 reset = 1'b0;
    #1;
    chk("arst_pos", pos_ship, 10);
    chk("arst_act", bullet_active, 2'b00);
    chk("arst_x", bullet_x, 0);
    chk("arst_y", bullet_y, 0);
    chk("arst_score", score, 0);
    chk("arst_start", start_pulse, 0);
    model_reset();
    repeat (2) cyc();
    reset = 1'b1;

    // random play
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 5) == 0) set_btn(4'($urandom));
      tick        = ($urandom_range(0, 3) == 0);
      hit         = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
      clear       = ($urandom_range(0, 99) == 0);
      score_clear = ($urandom_range(0, 149) == 0);
      cyc();
    end
    set_btn(4'b0000); tick = 1'b0; hit = 2'b00; clear = 1'b0; score_clear = 1'b0;
    repeat (5) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
